// File: rtl/prog_mem_if.sv
// rtl/prog_mem_if.sv - fetch and program-load bus of the instruction memory
interface prog_mem_if #(
  parameter int INS_W  = 9,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] pc;
  logic              fetch_en;
  logic [INS_W-1:0]  res_ins;
  logic              ins_valid;
  logic              ld_start;
  logic [INS_W-1:0]  ld_data;
  logic              ld_valid;
  logic              ld_last;
  logic              ld_ready;
  logic              ld_done;
  logic              busy;

  modport master (
    output pc, fetch_en, ld_start, ld_data, ld_valid, ld_last,
    input  res_ins, ins_valid, ld_ready, ld_done, busy
  );

  modport slave (
    input  pc, fetch_en, ld_start, ld_data, ld_valid, ld_last,
    output res_ins, ins_valid, ld_ready, ld_done, busy
  );
endinterface

// File: rtl/prog_mem.sv
// rtl/prog_mem.sv - instruction memory with NOP clear, registered fetch and streaming program load
module prog_mem #(
  parameter int               INS_W  = 9,
  parameter int               ADDR_W = 4,
  parameter logic [INS_W-1:0] NOP    = 9'b011000000
) (
  input  logic      clk,
  input  logic      rst,
  prog_mem_if.slave bus
);
  localparam int                DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {CLEAR, RUN, LOAD} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr, ld_ptr;
  logic [INS_W-1:0]  mem [DEPTH];
  logic [INS_W-1:0]  res_ins_q;
  logic              ins_valid_q, ld_done_q;

  logic              we, fetch, done_d, load_end;
  logic [ADDR_W-1:0] waddr;
  logic [INS_W-1:0]  wdata;

  always_comb begin
    state_d  = state_q;
    we       = 1'b0;
    waddr    = clr_ptr;
    wdata    = NOP;
    fetch    = 1'b0;
    done_d   = 1'b0;
    load_end = 1'b0;
    case (state_q)
      CLEAR: begin
        we = 1'b1;
        if (clr_ptr == LAST_ADDR) state_d = RUN;
      end
      RUN: begin
        fetch = bus.fetch_en;
        if (bus.ld_start) state_d = LOAD;
      end
      LOAD: begin
        if (bus.ld_valid) begin
          we    = 1'b1;
          waddr = ld_ptr;
          wdata = bus.ld_data;
          // Ending on the top address keeps ld_ptr from ever wrapping.
          if (bus.ld_last || ld_ptr == LAST_ADDR) begin
            load_end = 1'b1;
            done_d   = 1'b1;
            state_d  = RUN;
          end
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CLEAR;
      clr_ptr     <= '0;
      ld_ptr      <= '0;
      res_ins_q   <= NOP;
      ins_valid_q <= 1'b0;
      ld_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ins_valid_q <= fetch;
      ld_done_q   <= done_d;
      if (fetch) res_ins_q <= mem[bus.pc];
      if (state_q == CLEAR) clr_ptr <= clr_ptr + 1'b1;
      else                  clr_ptr <= '0;
      if (state_q == RUN && bus.ld_start)                      ld_ptr <= '0;
      else if (state_q == LOAD && bus.ld_valid && !load_end)   ld_ptr <= ld_ptr + 1'b1;
    end
  end

  // Writes are suppressed on a reset edge; the following clear rewrites everything anyway.
  always_ff @(posedge clk) begin
    if (we && !rst) mem[waddr] <= wdata;
  end

  assign bus.res_ins   = res_ins_q;
  assign bus.ins_valid = ins_valid_q;
  assign bus.ld_done   = ld_done_q;
  assign bus.ld_ready  = (state_q == LOAD);
  assign bus.busy      = (state_q == CLEAR) || (state_q == LOAD);
endmodule

// File: tb/tb_prog_mem.sv
// tb/tb_prog_mem.sv - randomized scoreboard bench for prog_mem
module tb_prog_mem;
  localparam logic [8:0] NOP_W = 9'b011000000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prog_mem_if #(.INS_W(9), .ADDR_W(4)) bus();
  prog_mem dut (.clk(clk), .rst(rst), .bus(bus));

  logic [8:0] ref_mem [16];
  logic [8:0] exp_q [$];
  logic [8:0] ld_q_data [$];
  bit         ld_q_valid [$];
  bit         ld_q_last [$];
  int         n_checks = 0;
  int         n_pass = 0;
  int         done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (bus.ld_done === 1'b1) done_cnt++;
    if (bus.ins_valid === 1'b1) begin
      if (exp_q.size() == 0) check("ins_valid_unexpected", 32'(bus.ins_valid), 32'd0);
      else check("fetch_data", 32'(bus.res_ins), 32'(exp_q.pop_front()));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.fetch_en = 1'b0;
    bus.ld_start = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
  endtask

  task automatic do_reset(input int hold);
    int cnt;
    idle_inputs();
    rst = 1'b1;
    repeat (hold) step();
    rst = 1'b0;
    for (int a = 0; a < 16; a++) ref_mem[a] = NOP_W;
    exp_q.delete();
    @(negedge clk);
    check("rst_res_ins", 32'(bus.res_ins), 32'(NOP_W));
    check("rst_ins_valid", 32'(bus.ins_valid), 32'd0);
    check("rst_ld_ready", 32'(bus.ld_ready), 32'd0);
    check("rst_ld_done", 32'(bus.ld_done), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd1);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.busy !== 1'b1) break;
      cnt++;
      @(negedge clk);
    end
    check("clear_cycles", 32'(cnt), 32'd16);
    @(posedge clk);
    #1;
  endtask

  // Fetch in RUN; random load-bus noise must not touch memory.
  task automatic fetch(input int a);
    bus.pc       = 4'(a);
    bus.fetch_en = 1'b1;
    bus.ld_valid = 1'($urandom);
    bus.ld_last  = 1'($urandom);
    bus.ld_data  = 9'($urandom);
    exp_q.push_back(ref_mem[a]);
    step();
    idle_inputs();
  endtask

  task automatic fetch_all();
    for (int a = 0; a < 16; a++) fetch(a);
    step();
    step();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_load(input int fetch_pc, input int abort_after);
    int  ptr;
    bit  ended;
    int  base;
    ptr   = 0;
    ended = 0;
    base  = done_cnt;
    bus.ld_start = 1'b1;
    if (fetch_pc >= 0) begin
      bus.pc       = 4'(fetch_pc);
      bus.fetch_en = 1'b1;
      exp_q.push_back(ref_mem[fetch_pc]);
    end
    step();
    idle_inputs();
    check("load_ld_ready", 32'(bus.ld_ready), 32'd1);
    check("load_busy", 32'(bus.busy), 32'd1);
    for (int i = 0; i < ld_q_data.size() && !ended; i++) begin
      if (i == abort_after) return;
      bus.ld_data  = ld_q_data[i];
      bus.ld_valid = ld_q_valid[i];
      bus.ld_last  = ld_q_last[i];
      bus.fetch_en = 1'($urandom);
      bus.pc       = 4'($urandom);
      bus.ld_start = 1'($urandom);
      step();
      if (ld_q_valid[i]) begin
        ref_mem[ptr] = ld_q_data[i];
        if (ld_q_last[i] || ptr == 15) ended = 1;
        ptr++;
      end
    end
    idle_inputs();
    step();
    step();
    check("load_ended", 32'(ended), 32'd1);
    check("ld_done_pulses", 32'(done_cnt - base), 32'd1);
    check("post_load_ready", 32'(bus.ld_ready), 32'd0);
    check("post_load_busy", 32'(bus.busy), 32'd0);
  endtask

  task automatic clear_q();
    ld_q_data.delete();
    ld_q_valid.delete();
    ld_q_last.delete();
  endtask

  task automatic push_word(input logic [8:0] d, input bit v, input bit l);
    ld_q_data.push_back(d);
    ld_q_valid.push_back(v);
    ld_q_last.push_back(l);
  endtask

  initial begin
    rst = 1'b1;
    bus.pc = '0;
    bus.ld_data = '0;
    idle_inputs();
    step();
    do_reset(3);
    fetch_all();

    clear_q();
    for (int i = 0; i < 16; i++) push_word(9'h100 + 9'(i), 1'b1, 1'b0);
    run_load(-1, -1);
    fetch(7);
    step();

    clear_q();
    push_word(9'h0AA, 1'b1, 1'b0);
    push_word(9'h0BB, 1'b1, 1'b0);
    push_word(9'h0CC, 1'b1, 1'b1);
    run_load(-1, -1);
    fetch(2);
    fetch(3);
    fetch_all();

    clear_q();
    for (int i = 0; i < 8; i++) push_word(9'h1E0 + 9'(i), (i % 2) == 0, i == 6);
    run_load(-1, -1);
    fetch_all();

    clear_q();
    for (int i = 0; i < 6; i++) push_word(9'h050 + 9'(i), 1'b1, i == 5);
    run_load(4, -1);
    fetch_all();

    clear_q();
    for (int i = 0; i < 16; i++) push_word(9'h1F0 - 9'(i), 1'b1, 1'b0);
    run_load(-1, 5);
    do_reset(1);
    fetch_all();

    repeat (6) begin
      int n;
      n = $urandom_range(1, 20);
      clear_q();
      for (int i = 0; i < n; i++)
        push_word(9'($urandom), (i == n - 1) ? 1'b1 : 1'($urandom),
                  (i == n - 1) ? 1'b1 : ($urandom_range(0, 7) == 0));
      run_load(($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 15)) : -1, -1);
      fetch_all();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
